// File: rtl/video_pkg.sv
// Shared raster geometry types, preset timings and total-length helpers.
// Latency: none, package only.
// Backpressure: not applicable.
package video_pkg;

  // Geometry of one raster: four regions per axis, in pixels and lines.
  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } vtiming_t;

  localparam vtiming_t VT_720P = '{
    h_active: 16'd1280, h_fp: 16'd110, h_sync: 16'd40, h_bp: 16'd220,
    v_active: 16'd720,  v_fp: 16'd5,   v_sync: 16'd5,  v_bp: 16'd20
  };
  localparam logic VT_720P_HS_POL = 1'b1;
  localparam logic VT_720P_VS_POL = 1'b1;

  localparam vtiming_t VT_480P = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33
  };
  localparam logic VT_480P_HS_POL = 1'b0;
  localparam logic VT_480P_VS_POL = 1'b0;

  function automatic int vt_htotal(input vtiming_t t);
    return int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
  endfunction

  function automatic int vt_vtotal(input vtiming_t t);
    return int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
  endfunction

endpackage

// File: rtl/vt_delay.sv
// Fixed-depth register pipeline with synchronous clear; depth 0 is a wire.
// Latency: exactly DEPTH cycles.
// Backpressure: none, shifts every cycle.
module vt_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk_pix,
  input  logic         srst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    // Clock and reset have no load in the pass-through build.
    logic unused_ok;
    assign unused_ok = clk_pix ^ srst;
    assign q = d;
  end else begin : g_pipe
    logic [W-1:0] stage [DEPTH];

    // Shift one stage per cycle; reset empties every stage at once.
    always_ff @(posedge clk_pix) begin
      if (srst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: syncs, DE, coordinates, early pixel requests.
// Latency: req is 1 cycle after the counters; de/syncs/x/y/sof/eol follow req by LEAD cycles.
// Backpressure: none, no enable or ready; timing depends only on srst.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   LEAD     = 2,
  parameter int   CW       = 12
) (
  input  logic          clk_pix,
  input  logic          srst,
  output logic          req,
  output logic [CW-1:0] req_x,
  output logic [CW-1:0] req_y,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          sof,
  output logic          eol,
  output logic [7:0]    frame_cnt
);

  localparam vtiming_t VT = '{
    h_active: 16'(H_ACTIVE), h_fp: 16'(H_FP), h_sync: 16'(H_SYNC), h_bp: 16'(H_BP),
    v_active: 16'(V_ACTIVE), v_fp: 16'(V_FP), v_sync: 16'(V_SYNC), v_bp: 16'(V_BP)
  };
  localparam int H_TOT = vt_htotal(VT);
  localparam int V_TOT = vt_vtotal(VT);

  // All boundaries resolved once at counter width.
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);

  localparam int SBW = 5 + 2 * CW;

  logic [CW-1:0] hcnt, vcnt;
  logic          h_act, v_act, act_now;

  logic          s0_act, s0_hs, s0_vs, s0_sof, s0_eol;
  logic [CW-1:0] s0_x, s0_y;

  logic          o_act, o_hs, o_vs, o_sof, o_eol;
  logic [CW-1:0] o_x, o_y;
  logic [SBW-1:0] sb_in, sb_out;

  // Master raster counters; vcnt steps only when hcnt wraps, both wrap together.
  always_ff @(posedge clk_pix) begin
    if (srst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  assign h_act   = (hcnt < H_ACT);
  assign v_act   = (vcnt < V_ACT);
  assign act_now = h_act && v_act;

  // Stage 0: registered region decode; coordinates zeroed outside the active area.
  always_ff @(posedge clk_pix) begin
    if (srst) begin
      s0_act <= 1'b0;
      s0_hs  <= 1'b0;
      s0_vs  <= 1'b0;
      s0_sof <= 1'b0;
      s0_eol <= 1'b0;
      s0_x   <= '0;
      s0_y   <= '0;
    end else begin
      s0_act <= act_now;
      s0_hs  <= (hcnt >= HS_START) && (hcnt < HS_END);
      s0_vs  <= (vcnt >= VS_START) && (vcnt < VS_END);
      s0_sof <= (hcnt == '0) && (vcnt == '0);
      s0_eol <= (hcnt == H_ACT_LAST) && v_act;
      s0_x   <= act_now ? hcnt : '0;
      s0_y   <= act_now ? vcnt : '0;
    end
  end

  assign req   = s0_act;
  assign req_x = s0_x;
  assign req_y = s0_y;

  // The whole side-band travels as one bundle so every output shares the same delay.
  assign sb_in = {s0_act, s0_hs, s0_vs, s0_x, s0_y, s0_sof, s0_eol};

  vt_delay #(
    .W     (SBW),
    .DEPTH (LEAD)
  ) u_delay (
    .clk_pix (clk_pix),
    .srst    (srst),
    .d       (sb_in),
    .q       (sb_out)
  );

  assign {o_act, o_hs, o_vs, o_x, o_y, o_sof, o_eol} = sb_out;

  assign de    = o_act;
  assign x     = o_x;
  assign y     = o_y;
  assign sof   = o_sof;
  assign eol   = o_eol;
  assign hsync = o_hs ? HS_POL : ~HS_POL;
  assign vsync = o_vs ? VS_POL : ~VS_POL;

  // Frame counter advances on the output-aligned start-of-frame pulse.
  always_ff @(posedge clk_pix) begin
    if (srst) begin
      frame_cnt <= '0;
    end else if (o_sof) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: 720p instance for reset and line timing, small-geometry
// instances (LEAD 2/0/8, low-active syncs) for frame, wrap and reset behaviour.
// Small raster: H 8/2/2/2 (14), V 4/1/1/1 (7), frame 98 cycles.
module tb_video_timing_gen;

  logic clk_pix = 1'b0;
  logic srst_hd = 1'b1;
  logic srst_sm = 1'b1;
  always #5 clk_pix = ~clk_pix;

  logic hd_req, hd_de, hd_hs, hd_vs, hd_sof, hd_eol;
  logic [11:0] hd_rx, hd_ry, hd_x, hd_y;
  logic [7:0] hd_fc;
  logic sm_req, sm_de, sm_hs, sm_vs, sm_sof, sm_eol;
  logic [11:0] sm_rx, sm_ry, sm_x, sm_y;
  logic [7:0] sm_fc;
  logic l0_req, l0_de, l0_hs, l0_vs, l0_sof, l0_eol;
  logic [11:0] l0_rx, l0_ry, l0_x, l0_y;
  logic [7:0] l0_fc;
  logic l8_req, l8_de, l8_hs, l8_vs, l8_sof, l8_eol;
  logic [11:0] l8_rx, l8_ry, l8_x, l8_y;
  logic [7:0] l8_fc;

  video_timing_gen #(.LEAD(2)) u_hd (
    .clk_pix(clk_pix), .srst(srst_hd), .req(hd_req), .req_x(hd_rx), .req_y(hd_ry),
    .de(hd_de), .hsync(hd_hs), .vsync(hd_vs), .x(hd_x), .y(hd_y),
    .sof(hd_sof), .eol(hd_eol), .frame_cnt(hd_fc));

  video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(2)) u_sm (
    .clk_pix(clk_pix), .srst(srst_sm), .req(sm_req), .req_x(sm_rx), .req_y(sm_ry),
    .de(sm_de), .hsync(sm_hs), .vsync(sm_vs), .x(sm_x), .y(sm_y),
    .sof(sm_sof), .eol(sm_eol), .frame_cnt(sm_fc));

  video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(0)) u_l0 (
    .clk_pix(clk_pix), .srst(srst_sm), .req(l0_req), .req_x(l0_rx), .req_y(l0_ry),
    .de(l0_de), .hsync(l0_hs), .vsync(l0_vs), .x(l0_x), .y(l0_y),
    .sof(l0_sof), .eol(l0_eol), .frame_cnt(l0_fc));

  video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(8)) u_l8 (
    .clk_pix(clk_pix), .srst(srst_sm), .req(l8_req), .req_x(l8_rx), .req_y(l8_ry),
    .de(l8_de), .hsync(l8_hs), .vsync(l8_vs), .x(l8_x), .y(l8_y),
    .sof(l8_sof), .eol(l8_eol), .frame_cnt(l8_fc));

  typedef struct packed {
    logic de, hs, vs, sof, eol;
    logic [11:0] x, y;
  } pix_t;

  int n_pass  = 0;
  int n_total = 0;
  int hd_cyc  = 0;
  int sm_c    = 0;
  int mis_sm = 0, mis_l0 = 0, mis_l8 = 0, mis_al = 0;
  logic [24:0] h_sm [0:8];
  logic [24:0] h_l0 [0:8];
  logic [24:0] h_l8 [0:8];

  // Expected raster state at stage-0 position p (p<0: nothing emitted yet).
  function automatic pix_t model(input int p);
    pix_t e;
    int h, v;
    e = '0;
    if (p >= 0) begin
      h = p % 14;
      v = (p / 14) % 7;
      e.de  = (h < 8) && (v < 4);
      e.hs  = (h >= 10) && (h < 12);
      e.vs  = (v == 5);
      e.sof = (h == 0) && (v == 0);
      e.eol = (h == 7) && (v < 4);
      if (e.de) begin
        e.x = 12'(h);
        e.y = 12'(v);
      end
    end
    return e;
  endfunction

  function automatic int eval_inst(input int c, input int lead, input logic req,
      input logic [11:0] rx, input logic [11:0] ry, input logic de, input logic hs,
      input logic vs, input logic sf, input logic el, input logic [11:0] px,
      input logic [11:0] py, input logic [7:0] fc);
    pix_t e, r;
    int m, k;
    m = 0;
    e = model(c - 1 - lead);
    r = model(c - 1);
    k = (c - 2 - lead < 0) ? 0 : ((c - 2 - lead) / 98 + 1) % 256;
    if (de !== e.de) m++;
    if (hs !== ~e.hs) m++;
    if (vs !== ~e.vs) m++;
    if (sf !== e.sof) m++;
    if (el !== e.eol) m++;
    if (px !== e.x) m++;
    if (py !== e.y) m++;
    if (req !== r.de) m++;
    if (rx !== r.x) m++;
    if (ry !== r.y) m++;
    if (fc !== 8'(k)) m++;
    return m;
  endfunction

  task automatic hd_step();
    @(posedge clk_pix);
    #1;
    hd_cyc++;
  endtask

  // Compare all small instances against the model and the req history.
  task automatic sample_small();
    mis_sm += eval_inst(sm_c, 2, sm_req, sm_rx, sm_ry, sm_de, sm_hs, sm_vs, sm_sof, sm_eol, sm_x, sm_y, sm_fc);
    mis_l0 += eval_inst(sm_c, 0, l0_req, l0_rx, l0_ry, l0_de, l0_hs, l0_vs, l0_sof, l0_eol, l0_x, l0_y, l0_fc);
    mis_l8 += eval_inst(sm_c, 8, l8_req, l8_rx, l8_ry, l8_de, l8_hs, l8_vs, l8_sof, l8_eol, l8_x, l8_y, l8_fc);
    for (int i = 8; i > 0; i--) begin
      h_sm[i] = h_sm[i-1];
      h_l0[i] = h_l0[i-1];
      h_l8[i] = h_l8[i-1];
    end
    h_sm[0] = {sm_req, sm_rx, sm_ry};
    h_l0[0] = {l0_req, l0_rx, l0_ry};
    h_l8[0] = {l8_req, l8_rx, l8_ry};
    if ({sm_de, sm_x, sm_y} !== h_sm[2]) mis_al++;
    if ({l0_de, l0_x, l0_y} !== h_l0[0]) mis_al++;
    if ({l8_de, l8_x, l8_y} !== h_l8[8]) mis_al++;
  endtask

  task automatic step_small();
    @(posedge clk_pix);
    #1;
    sm_c++;
    sample_small();
  endtask

  // Called at #1 after a posedge that sampled srst_sm=1: releases into cycle 0.
  task automatic release_small();
    srst_sm = 1'b0;
    sm_c = 0;
    for (int i = 0; i < 9; i++) begin
      h_sm[i] = '0;
      h_l0[i] = '0;
      h_l8[i] = '0;
    end
    sample_small();
  endtask

  task automatic test_reset();
    srst_hd = 1'b1;
    repeat (5) @(posedge clk_pix);
    #1;
    srst_hd = 1'b0;
    hd_cyc = 0;
    n_total++; if ({hd_req, hd_de, hd_sof, hd_eol} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {hd_req, hd_de, hd_sof, hd_eol}); else n_pass++;
    n_total++; if ({hd_x, hd_y, hd_rx, hd_ry} !== 48'd0) $display("FAIL reset_coords: got %h want 0", {hd_x, hd_y, hd_rx, hd_ry}); else n_pass++;
    n_total++; if (hd_fc !== 8'd0) $display("FAIL reset_frame_cnt: got %0d want 0", hd_fc); else n_pass++;
    n_total++; if ({hd_hs, hd_vs} !== 2'b00) $display("FAIL reset_syncs: got %b want 00", {hd_hs, hd_vs}); else n_pass++;
    hd_step();
    n_total++; if ({hd_req, hd_rx, hd_ry, hd_de} !== {1'b1, 24'd0, 1'b0}) $display("FAIL cyc1_req: got req=%b x=%0d y=%0d de=%b want 1/0/0/0", hd_req, hd_rx, hd_ry, hd_de); else n_pass++;
    hd_step();
    n_total++; if ({hd_de, hd_rx} !== {1'b0, 12'd1}) $display("FAIL cyc2: got de=%b req_x=%0d want 0/1", hd_de, hd_rx); else n_pass++;
    hd_step();
    n_total++; if ({hd_de, hd_sof, hd_x, hd_y} !== {2'b11, 24'd0}) $display("FAIL cyc3_de_sof: got de=%b sof=%b x=%0d y=%0d want 1/1/0/0", hd_de, hd_sof, hd_x, hd_y); else n_pass++;
    n_total++; if (hd_fc !== 8'd0) $display("FAIL cyc3_frame_cnt: got %0d want 0", hd_fc); else n_pass++;
    hd_step();
    n_total++; if ({hd_fc, hd_sof, hd_x} !== {8'd1, 1'b0, 12'd1}) $display("FAIL cyc4: got fc=%0d sof=%b x=%0d want 1/0/1", hd_fc, hd_sof, hd_x); else n_pass++;
  endtask

  task automatic test_line();
    int de_fall = -1, de_rise2 = -1, hs_rise = -1, hs_fall = -1, eol_c = -1;
    int vs_seen = 0, mis = 0;
    logic [11:0] eol_x = '0, rise_x = '1, rise_y = '1;
    logic [24:0] hist [0:2];
    for (int i = 0; i < 3; i++) hist[i] = '0;
    while (hd_cyc < 1660) begin
      hd_step();
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = {hd_req, hd_rx, hd_ry};
      if (hd_cyc >= 7 && {hd_de, hd_x, hd_y} !== hist[2]) mis++;
      if (de_fall < 0 && !hd_de) de_fall = hd_cyc;
      if (de_fall >= 0 && de_rise2 < 0 && hd_de) begin
        de_rise2 = hd_cyc;
        rise_x = hd_x;
        rise_y = hd_y;
      end
      if (hs_rise < 0 && hd_hs) hs_rise = hd_cyc;
      if (hs_rise >= 0 && hs_fall < 0 && !hd_hs) hs_fall = hd_cyc;
      if (eol_c < 0 && hd_eol) begin
        eol_c = hd_cyc;
        eol_x = hd_x;
      end
      if (hd_vs) vs_seen++;
    end
    n_total++; if (de_fall - 3 != 1280) $display("FAIL line_de_width: got %0d want 1280", de_fall - 3); else n_pass++;
    n_total++; if (hs_rise - de_fall != 110) $display("FAIL line_front_porch: got %0d want 110", hs_rise - de_fall); else n_pass++;
    n_total++; if (hs_fall - hs_rise != 40) $display("FAIL line_hsync_width: got %0d want 40", hs_fall - hs_rise); else n_pass++;
    n_total++; if (de_rise2 - 3 != 1650) $display("FAIL line_period: got %0d want 1650", de_rise2 - 3); else n_pass++;
    n_total++; if ({rise_x, rise_y} !== {12'd0, 12'd1}) $display("FAIL line2_coords: got x=%0d y=%0d want 0/1", rise_x, rise_y); else n_pass++;
    n_total++; if (eol_c != 1282 || eol_x !== 12'd1279) $display("FAIL line_eol: got cyc=%0d x=%0d want 1282/1279", eol_c, eol_x); else n_pass++;
    n_total++; if (vs_seen != 0) $display("FAIL line_vsync_quiet: got %0d want 0", vs_seen); else n_pass++;
    n_total++; if (mis != 0) $display("FAIL line_alignment: got %0d mismatches want 0", mis); else n_pass++;
  endtask

  task automatic test_small_frame();
    int sof1 = -1, sof2 = -1, hs_first = -1, vs_first = -1, l0_first = -1, l8_first = -1;
    int vs_n = 0, hs_n = 0, de_n = 0, eol_n = 0;
    logic [7:0] fc4 = '1, fc102 = '1;
    logic [25:0] at101 = '1;
    @(posedge clk_pix);
    #1;
    release_small();
    n_total++; if ({sm_hs, sm_vs} !== 2'b11) $display("FAIL sm_reset_syncs: got %b want 11", {sm_hs, sm_vs}); else n_pass++;
    n_total++; if ({sm_de, sm_req, sm_fc} !== 10'd0) $display("FAIL sm_reset_de_fc: got de=%b req=%b fc=%0d want 0/0/0", sm_de, sm_req, sm_fc); else n_pass++;
    while (sm_c < 102) begin
      step_small();
      if (sm_sof && sof1 < 0) sof1 = sm_c;
      else if (sm_sof && sof2 < 0) sof2 = sm_c;
      if (!sm_hs && hs_first < 0) hs_first = sm_c;
      if (!sm_vs && vs_first < 0) vs_first = sm_c;
      if (l0_de && l0_first < 0) l0_first = sm_c;
      if (l8_de && l8_first < 0) l8_first = sm_c;
      if (sm_c >= 3 && sm_c <= 100) begin
        vs_n += int'(!sm_vs);
        hs_n += int'(!sm_hs);
        de_n += int'(sm_de);
        eol_n += int'(sm_eol);
      end
      if (sm_c == 4) fc4 = sm_fc;
      if (sm_c == 102) fc102 = sm_fc;
      if (sm_c == 101) at101 = {sm_de, sm_sof, sm_x, sm_y};
    end
    n_total++; if (sof1 != 3 || sof2 != 101) $display("FAIL sm_sof_period: got %0d,%0d want 3,101", sof1, sof2); else n_pass++;
    n_total++; if (hs_first != 13 || hs_n != 14) $display("FAIL sm_hsync: got first=%0d count=%0d want 13/14", hs_first, hs_n); else n_pass++;
    n_total++; if (vs_first != 73 || vs_n != 14) $display("FAIL sm_vsync: got first=%0d count=%0d want 73/14", vs_first, vs_n); else n_pass++;
    n_total++; if (de_n != 32 || eol_n != 4) $display("FAIL sm_de_eol: got de=%0d eol=%0d want 32/4", de_n, eol_n); else n_pass++;
    n_total++; if (fc4 !== 8'd1 || fc102 !== 8'd2) $display("FAIL sm_frame_cnt: got %0d,%0d want 1,2", fc4, fc102); else n_pass++;
    n_total++; if (at101 !== {2'b11, 24'd0}) $display("FAIL sm_wrap_no_gap: got %h want %h", at101, {2'b11, 24'd0}); else n_pass++;
    n_total++; if (l0_first != 1 || l8_first != 9) $display("FAIL lead_first_de: got l0=%0d l8=%0d want 1/9", l0_first, l8_first); else n_pass++;
  endtask

  task automatic test_frame_wrap();
    logic [7:0] fa = '0, fb = '1, fcc = '0;
    int sof_n = 0;
    while (sm_c < 29310) begin
      step_small();
      if (sm_sof) sof_n++;
      if (sm_c == 24896) fa = sm_fc;
      if (sm_c == 24994) fb = sm_fc;
      if (sm_c == 29306) fcc = sm_fc;
    end
    n_total++; if (fa !== 8'd255 || fb !== 8'd0) $display("FAIL fc_wrap: got %0d->%0d want 255->0", fa, fb); else n_pass++;
    n_total++; if (fcc !== 8'd44) $display("FAIL fc_300_frames: got %0d want 44", fcc); else n_pass++;
    n_total++; if (sof_n != 298) $display("FAIL sof_count: got %0d want 298", sof_n); else n_pass++;
  endtask

  task automatic test_alignment();
    n_total++; if (mis_sm != 0) $display("FAIL model_lead2: got %0d mismatches want 0", mis_sm); else n_pass++;
    n_total++; if (mis_l0 != 0) $display("FAIL model_lead0: got %0d mismatches want 0", mis_l0); else n_pass++;
    n_total++; if (mis_l8 != 0) $display("FAIL model_lead8: got %0d mismatches want 0", mis_l8); else n_pass++;
    n_total++; if (mis_al != 0) $display("FAIL req_to_de_alignment: got %0d mismatches want 0", mis_al); else n_pass++;
    mis_sm = 0; mis_l0 = 0; mis_l8 = 0; mis_al = 0;
  endtask

  task automatic test_reset_mid();
    int found = 0, held_de = 0, mis_before;
    for (int i = 0; i < 200 && found == 0; i++) begin
      step_small();
      if (sm_de && sm_y == 12'd2 && sm_x == 12'd5) found = 1;
    end
    n_total++; if (found != 1) $display("FAIL mid_reset_reach: got %0d want 1", found); else n_pass++;
    srst_sm = 1'b1;
    @(posedge clk_pix);
    #1;
    n_total++; if ({sm_de, sm_req, sm_hs, sm_vs, sm_fc} !== {4'b0011, 8'd0}) $display("FAIL mid_reset_state: got de=%b req=%b hs=%b vs=%b fc=%0d want 0/0/1/1/0", sm_de, sm_req, sm_hs, sm_vs, sm_fc); else n_pass++;
    repeat (3) begin
      @(posedge clk_pix);
      #1;
      held_de += int'(sm_de) + int'(l0_de) + int'(l8_de);
    end
    n_total++; if (held_de != 0) $display("FAIL mid_reset_pipe_clear: got %0d de cycles want 0", held_de); else n_pass++;
    release_small();
    while (sm_c < 120) step_small();
    mis_before = mis_sm + mis_l0 + mis_l8 + mis_al;
    n_total++; if (mis_before != 0) $display("FAIL mid_reset_restart: got %0d mismatches want 0", mis_before); else n_pass++;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      step_small();
      if (!sm_hs && !sm_vs) found = 1;
    end
    n_total++; if (found != 1) $display("FAIL sync_reset_reach: got %0d want 1", found); else n_pass++;
    srst_sm = 1'b1;
    @(posedge clk_pix);
    #1;
    n_total++; if ({sm_hs, sm_vs, l0_hs, l0_vs, l8_hs, l8_vs} !== 6'b111111) $display("FAIL sync_reset_release: got %b want 111111", {sm_hs, sm_vs, l0_hs, l0_vs, l8_hs, l8_vs}); else n_pass++;
    release_small();
    while (sm_c < 110) step_small();
    mis_before = mis_sm + mis_l0 + mis_l8 + mis_al;
    n_total++; if (mis_before != 0) $display("FAIL sync_reset_restart: got %0d mismatches want 0", mis_before); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_line();
    test_small_frame();
    test_frame_wrap();
    test_alignment();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
